// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding, default timing constants and counter sizing for the button debouncer
package btn_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED  = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } btn_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 120000;
  localparam int DEFAULT_LONG_CYCLES     = 12000000;
  localparam int MAX_DEBOUNCE_W          = 20;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEFAULT_DEBOUNCE_W = cnt_width(DEFAULT_DEBOUNCE_CYCLES);
  localparam int DEFAULT_LONG_W     = cnt_width(DEFAULT_LONG_CYCLES);

endpackage

// File: rtl/btn_sync.sv
// rtl/btn_sync.sv - two-flop synchronizer for one asynchronous pin
module btn_sync (
  input  logic CLK,
  input  logic RST_N,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - debounced level plus press, release and long-press pulses for one button
module button_debouncer
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN,
  output logic BTN_LEVEL,
  output logic BTN_PRESS,
  output logic BTN_RELEASE,
  output logic BTN_LONG
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int LG_W = cnt_width(LONG_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYCLES - 1);

  logic            sync;
  logic [DB_W-1:0] db_cnt, db_cnt_nxt;
  logic [LG_W-1:0] hold_cnt, hold_cnt_nxt;
  btn_state_t      state, state_nxt;
  logic            mismatch, accept;
  logic            level_nxt, press_nxt, release_nxt, long_nxt;

  btn_sync u_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .d     (BTN),
    .q     (sync)
  );

  always_comb begin
    mismatch     = (sync != BTN_LEVEL);
    accept       = mismatch && (db_cnt == DB_LAST);
    db_cnt_nxt   = (!mismatch || accept) ? '0 : db_cnt + DB_W'(1);
    level_nxt    = accept ? sync : BTN_LEVEL;
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    press_nxt    = 1'b0;
    release_nxt  = 1'b0;
    long_nxt     = 1'b0;
    case (state)
      ST_RELEASED: begin
        if (accept && sync) begin
          state_nxt    = ST_PRESSED;
          hold_cnt_nxt = '0;
          press_nxt    = 1'b1;
        end
      end
      ST_PRESSED: begin
        // An accepted release outranks a long press landing on the same edge.
        if (accept && !sync) begin
          state_nxt   = ST_RELEASED;
          release_nxt = 1'b1;
        end else if (hold_cnt == LG_LAST) begin
          state_nxt = ST_LONG_HELD;
          long_nxt  = 1'b1;
        end else begin
          hold_cnt_nxt = hold_cnt + LG_W'(1);
        end
      end
      ST_LONG_HELD: begin
        if (accept && !sync) begin
          state_nxt   = ST_RELEASED;
          release_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_RELEASED;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= ST_RELEASED;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      BTN_LEVEL   <= 1'b0;
      BTN_PRESS   <= 1'b0;
      BTN_RELEASE <= 1'b0;
      BTN_LONG    <= 1'b0;
    end else begin
      state       <= state_nxt;
      db_cnt      <= db_cnt_nxt;
      hold_cnt    <= hold_cnt_nxt;
      BTN_LEVEL   <= level_nxt;
      BTN_PRESS   <= press_nxt;
      BTN_RELEASE <= release_nxt;
      BTN_LONG    <= long_nxt;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - self-checking bench for button_debouncer with a window-based reference model
module tb_button_debouncer;

  localparam int D = 4;
  localparam int L = 10;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic BTN = 1'b0;
  logic BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_LONG;

  always #5 CLK = ~CLK;

  button_debouncer #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .BTN         (BTN),
    .BTN_LEVEL   (BTN_LEVEL),
    .BTN_PRESS   (BTN_PRESS),
    .BTN_RELEASE (BTN_RELEASE),
    .BTN_LONG    (BTN_LONG)
  );

  int checks = 0;
  int failures = 0;
  int tick_no = 0;
  int n_press, n_release, n_long;
  int last_press, last_release, last_long;

  // Reference: sync is BTN delayed two edges; level flips once the last D sync samples all disagree with it.
  bit [1:0] m_pipe;
  bit       m_hist[$];
  bit       m_level;
  int       m_age;
  bit       m_long_done;
  bit [3:0] m_exp;

  function automatic void model_step(input bit b, input bit r);
    bit sync_now, all_diff, new_level, p, rl, lg;
    if (!r) begin
      m_pipe = 2'b00;
      m_hist.delete();
      m_level = 1'b0;
      m_age = 0;
      m_long_done = 1'b0;
      m_exp = 4'b0000;
      return;
    end
    sync_now = m_pipe[1];
    m_hist.push_back(sync_now);
    if (m_hist.size() > D) void'(m_hist.pop_front());
    all_diff = (m_hist.size() == D);
    foreach (m_hist[i]) if (m_hist[i] == m_level) all_diff = 1'b0;
    new_level = all_diff ? ~m_level : m_level;
    p  = !m_level && new_level;
    rl = m_level && !new_level;
    lg = 1'b0;
    if (p) begin
      m_age = 0;
      m_long_done = 1'b0;
    end else if (m_level && new_level) begin
      m_age++;
      if (m_age == L && !m_long_done) begin
        lg = 1'b1;
        m_long_done = 1'b1;
      end
    end
    m_level = new_level;
    m_pipe = {m_pipe[0], b};
    m_exp = {new_level, p, rl, lg};
  endfunction

  task automatic check_vec(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s tick=%0d got={lvl,prs,rel,lng}=%b expected=%b", name, tick_no, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_LONG};
  endfunction

  task automatic clear_counts();
    n_press = 0; n_release = 0; n_long = 0;
    last_press = -1; last_release = -1; last_long = -1;
  endtask

  // Drive one cycle, advance the model on the edge, then compare on the falling edge.
  task automatic tick(input bit b, input bit r);
    logic [3:0] got;
    BTN = b;
    RST_N = r;
    @(posedge CLK);
    model_step(b, r);
    @(negedge CLK);
    tick_no++;
    got = outs();
    if (got[2] === 1'b1) begin n_press++;   last_press = tick_no;   end
    if (got[1] === 1'b1) begin n_release++; last_release = tick_no; end
    if (got[0] === 1'b1) begin n_long++;    last_long = tick_no;    end
    check_vec("model", got, m_exp);
  endtask

  typedef struct {
    bit         btn;
    bit         rst_n;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int rise_tick, fall_tick, p, r;
    clear_counts();

    vecs[0] = '{1'b0, 1'b0, 4'b0000};
    vecs[1] = '{1'b1, 1'b1, 4'b0000};
    vecs[2] = '{1'b1, 1'b1, 4'b0000};
    vecs[3] = '{1'b1, 1'b1, 4'b0000};
    vecs[4] = '{1'b1, 1'b1, 4'b0000};
    vecs[5] = '{1'b1, 1'b1, 4'b0000};
    vecs[6] = '{1'b1, 1'b1, 4'b1100};
    vecs[7] = '{1'b1, 1'b1, 4'b1000};
    vecs[8] = '{1'b1, 1'b1, 4'b1000};
    vecs[9] = '{1'b0, 1'b1, 4'b1000};

    @(negedge CLK);
    for (int i = 0; i < 10; i++) begin
      tick(vecs[i].btn, vecs[i].rst_n);
      check_vec($sformatf("table_%0d", i), outs(), vecs[i].exp);
    end

    // Bounce: 2-cycle pulses never survive the debounce window.
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
    clear_counts();
    for (int i = 0; i < 40; i++) tick(((i / 2) % 2) == 0, 1'b1);
    check_int("toggle_no_pulse", n_press + n_release + n_long, 0);
    rise_tick = tick_no + 1;
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b1);
    check_int("toggle_press_count", n_press, 1);
    check_int("toggle_press_latency", last_press - rise_tick + 1, D + 2);

    // Long hold then release.
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
    clear_counts();
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b1);
    check_int("hold_press_count", n_press, 1);
    check_int("hold_long_count", n_long, 1);
    check_int("hold_long_delay", last_long - last_press, L);
    fall_tick = tick_no + 1;
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
    check_int("hold_release_count", n_release, 1);
    check_int("hold_release_latency", last_release - fall_tick + 1, D + 2);

    // Release accepted on the very edge the long press would fire.
    clear_counts();
    for (int i = 0; i < 20; i++) if (n_press == 0) tick(1'b1, 1'b1);
    check_int("race_press_seen", n_press, 1);
    p = last_press;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
    check_int("race_no_long", n_long, 0);
    check_int("race_release_count", n_release, 1);
    check_int("race_release_tick", last_release - p, L);

    // Reset while pressed aborts silently; held button re-presses after the window.
    clear_counts();
    for (int i = 0; i < 20; i++) if (n_press == 0) tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    check_vec("reset_mid_press", outs(), 4'b0000);
    r = tick_no;
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);
    check_int("reset_no_release", n_release, 0);
    check_int("reset_press_count", n_press, 2);
    check_int("reset_repress_latency", last_press - r, D + 2);

    // Random runs with occasional resets, checked cycle by cycle against the model.
    begin
      int left;
      bit lvl;
      left = 0;
      lvl = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if (left == 0) begin
          lvl = $urandom_range(0, 1);
          left = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 6);
        end
        left--;
        tick(lvl, ($urandom_range(0, 149) != 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 120000, giving consecutive stable cycles required to accept a level change (10 ms at 12 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter LONG_CYCLES, default 12000000, giving debounced-high cycles before a long-press event (1 s at 12 MHz); SHALL be greater than DEBOUNCE_CYCLES.
REQ-003 SHALL have port CLK, input, 1 bit: FPGA clock; all logic is on its rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port BTN, input, 1 bit: raw asynchronous button pin, active-high, bouncing.
REQ-006 SHALL have port BTN_LEVEL, output, 1 bit: debounced button level.
REQ-007 SHALL have port BTN_PRESS, output, 1 bit: one-cycle pulse on the accepted 0->1 change; this is the toggle stage's input.
REQ-008 SHALL have port BTN_RELEASE, output, 1 bit: one-cycle pulse on the accepted 1->0 change.
REQ-009 SHALL have port BTN_LONG, output, 1 bit: one-cycle pulse, at most once per press, after LONG_CYCLES held.

Function
REQ-010 SHALL pass BTN through a 2-flop synchronizer; downstream logic SHALL use only the synchronized bit (sync).
REQ-011 Debounce counter: SHALL clear to 0 in any cycle where sync == BTN_LEVEL, and SHALL increment while sync != BTN_LEVEL.
REQ-012 When the counter equals DEBOUNCE_CYCLES-1 and sync != BTN_LEVEL, BTN_LEVEL SHALL take sync on that edge, and the counter SHALL clear.
REQ-013 Latency from a clean BTN edge to BTN_LEVEL change SHALL be exactly DEBOUNCE_CYCLES+2 cycles.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL restart the count and SHALL NOT change BTN_LEVEL or pulse any output.
REQ-015 The FSM SHALL have states RELEASED, PRESSED and LONG_HELD.
REQ-016 RELEASED->PRESSED on accepted 0->1: BTN_PRESS=1 for exactly the one cycle in which BTN_LEVEL first reads 1.
REQ-017 PRESSED->LONG_HELD when the hold counter reaches LONG_CYCLES-1: BTN_LONG=1 for one cycle.
REQ-018 PRESSED or LONG_HELD->RELEASED on accepted 1->0: BTN_RELEASE=1 for one cycle, coincident with BTN_LEVEL first reading 0.
REQ-019 Hold counter: SHALL clear on entering PRESSED, increment in PRESSED, and hold (no wrap) in LONG_HELD and RELEASED.
REQ-020 The pulses BTN_PRESS, BTN_RELEASE and BTN_LONG SHALL be mutually exclusive; at most one is high per cycle.
REQ-021 A release accepted in the same cycle the hold counter would reach LONG_CYCLES-1 SHALL produce BTN_RELEASE only; release takes priority.
REQ-022 All outputs SHALL be registered, with no combinational path from BTN to any output.

Reset
REQ-023 When RST_N=0 at a clock edge, the synchronizer flops SHALL be 0, both counters 0, state RELEASED, BTN_LEVEL=0 and all pulses 0.
REQ-024 Reset asserted mid-press SHALL abort without emitting BTN_RELEASE.
REQ-025 After reset is released with BTN held high, BTN_PRESS SHALL fire DEBOUNCE_CYCLES+2 cycles later.
REQ-026 No initial-block values SHALL be relied upon; RST_N defines all state.

Structure
REQ-027 Shared package btn_pkg SHALL hold the FSM state encoding, default cycle constants and a clog2-based counter-width constant.
REQ-028 Counter widths SHALL be sized from the parameters; the debounce counter SHALL NOT exceed 20 bits.
REQ-029 The synchronizer SHALL be a separate sub-module btn_sync (2 flops, 1 bit, synchronous active-low reset), reused by other pin inputs.
REQ-030 Target size is 120-250 RTL lines, with no vendor primitives.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10)
REQ-031 Clean BTN 0->1 at cycle 0 -> BTN_PRESS and BTN_LEVEL rise at cycle 6; BTN_PRESS is high exactly 1 cycle.
REQ-032 BTN toggling 1/0 every 2 cycles for 40 cycles, then high -> no pulse during toggling; exactly one BTN_PRESS, 6 cycles after the final rise.
REQ-033 BTN held high 30 cycles -> BTN_PRESS, then BTN_LONG exactly 10 cycles later, once; on release, one BTN_RELEASE 6 cycles after the BTN fall.
REQ-034 Release timed so the 1->0 is accepted on the hold-count 9 cycle -> BTN_RELEASE only, with no BTN_LONG.
REQ-035 RST_N low for 1 cycle while PRESSED -> all outputs 0 next cycle, no BTN_RELEASE; with BTN still high, BTN_PRESS fires 6 cycles after RST_N returns high.
